// File: rtl/cpu_controller_fsm_if.sv
// rtl/cpu_controller_fsm_if.sv - decoder/datapath control bundle for cpu_controller_fsm
//
// Groups the controller's start/decode inputs and all datapath control outputs.
//   master : the controller side (drives control, reads s/opcode/op)
//   slave  : the decoder/datapath side (drives s/opcode/op, reads control)
//
// Signals:
//   s         start request, sampled only while idle
//   opcode    instruction[15:13]
//   op        instruction[12:11]
//   w         idle / ready for next instruction
//   nsel      one-hot register select: 001=Rn, 010=Rd, 100=Rm
//   vsel      writeback source: 00=C, 01=mdata, 10=sximm8
//   write     register-file write enable
//   loada     load A latch
//   loadb     load B latch
//   asel      force ALU A input to 0
//   bsel      select sximm5 as ALU B input
//   loadc     load C latch
//   loads     load status flags
//   mem_cmd   00=none, 01=read, 10=write
//   load_addr load data-address register from C

interface cpu_controller_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic [1:0] mem_cmd;
    logic       load_addr;

    modport master (
        input  s, opcode, op,
        output w, nsel, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, mem_cmd, load_addr
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, mem_cmd, load_addr
    );
endinterface

// File: rtl/cpu_controller_fsm.sv
// rtl/cpu_controller_fsm.sv - Moore controller sequencing the 16-bit CPU datapath
//
// Steps the register-file/ALU datapath through one decoded instruction at a
// time. Every control output is a function of the current state only.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high; returns to WAIT
//   bus    cpu_controller_fsm_if.master (s/opcode/op in, datapath control out)
//
// Parameters:
//   STATE_BITS  width of the state register (must hold every state)
//
// Build option:
//   CPU_LDR_STR_EN  when defined, adds LDR (011_00) and STR (100_00) with the
//                   address/memory states; otherwise mem_cmd and load_addr are 0
//                   and both opcodes return straight to WAIT.

module cpu_controller_fsm #(
    parameter int STATE_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_controller_fsm_if.master bus
);

    localparam logic [STATE_BITS-1:0] S_WAIT      = 'd0;
    localparam logic [STATE_BITS-1:0] S_DECODE    = 'd1;
    localparam logic [STATE_BITS-1:0] S_WRITE_IMM = 'd2;
    localparam logic [STATE_BITS-1:0] S_GET_A     = 'd3;
    localparam logic [STATE_BITS-1:0] S_GET_B     = 'd4;
    // The ALU step is split into three codes so asel/loads stay pure state
    // decodes: plain (loadc), negate/move (asel+loadc) and compare (loads).
    localparam logic [STATE_BITS-1:0] S_ALU       = 'd5;
    localparam logic [STATE_BITS-1:0] S_ALU_ASEL  = 'd6;
    localparam logic [STATE_BITS-1:0] S_ALU_CMP   = 'd7;
    localparam logic [STATE_BITS-1:0] S_WRITE_REG = 'd8;
    localparam logic [STATE_BITS-1:0] S_HALT      = 'd9;
`ifdef CPU_LDR_STR_EN
    localparam logic [STATE_BITS-1:0] S_ADDR      = 'd10;
    localparam logic [STATE_BITS-1:0] S_LOAD_ADDR = 'd11;
    localparam logic [STATE_BITS-1:0] S_MEM_RD    = 'd12;
    localparam logic [STATE_BITS-1:0] S_WRITE_MEM = 'd13;
    localparam logic [STATE_BITS-1:0] S_GET_RD    = 'd14;
    localparam logic [STATE_BITS-1:0] S_PASS      = 'd15;
    localparam logic [STATE_BITS-1:0] S_MEM_WR    = 'd16;
`endif

    logic [STATE_BITS-1:0] state_q;
    logic [STATE_BITS-1:0] state_d;
    logic [4:0]            instr;

    assign instr = {bus.opcode, bus.op};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                casez (instr)
                    5'b110_10:                   state_d = S_WRITE_IMM;
                    5'b110_00, 5'b101_11:        state_d = S_GET_B;
                    5'b101_00, 5'b101_01,
                    5'b101_10:                   state_d = S_GET_A;
                    5'b111_??:                   state_d = S_HALT;
`ifdef CPU_LDR_STR_EN
                    5'b011_00, 5'b100_00:        state_d = S_GET_A;
`endif
                    default:                     state_d = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A: begin
`ifdef CPU_LDR_STR_EN
                if (instr == 5'b011_00 || instr == 5'b100_00) state_d = S_ADDR;
                else                                          state_d = S_GET_B;
`else
                state_d = S_GET_B;
`endif
            end
            // opcode/op are re-read here to pick the ALU flavour.
            S_GET_B: begin
                if (instr == 5'b101_01)                           state_d = S_ALU_CMP;
                else if (instr == 5'b110_00 || instr == 5'b101_11) state_d = S_ALU_ASEL;
                else                                              state_d = S_ALU;
            end
            S_ALU, S_ALU_ASEL: state_d = S_WRITE_REG;
            S_ALU_CMP:         state_d = S_WAIT;
            S_WRITE_REG:       state_d = S_WAIT;
            S_HALT:            state_d = S_HALT;
`ifdef CPU_LDR_STR_EN
            S_ADDR:      state_d = S_LOAD_ADDR;
            S_LOAD_ADDR: state_d = (bus.opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:    state_d = S_WRITE_MEM;
            S_WRITE_MEM: state_d = S_WAIT;
            S_GET_RD:    state_d = S_PASS;
            S_PASS:      state_d = S_MEM_WR;
            S_MEM_WR:    state_d = S_WAIT;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w         = 1'b0;
        bus.nsel      = 3'b000;
        bus.vsel      = 2'b00;
        bus.write     = 1'b0;
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.asel      = 1'b0;
        bus.bsel      = 1'b0;
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.mem_cmd   = 2'b00;
        bus.load_addr = 1'b0;
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_WRITE_IMM: begin
                bus.nsel  = 3'b001;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
            end
            S_GET_A: begin
                bus.nsel  = 3'b001;
                bus.loada = 1'b1;
            end
            S_GET_B: begin
                bus.nsel  = 3'b100;
                bus.loadb = 1'b1;
            end
            S_ALU:      bus.loadc = 1'b1;
            S_ALU_ASEL: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_ALU_CMP:  bus.loads = 1'b1;
            S_WRITE_REG: begin
                bus.nsel  = 3'b010;
                bus.write = 1'b1;
            end
`ifdef CPU_LDR_STR_EN
            S_ADDR: begin
                bus.bsel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_LOAD_ADDR: bus.load_addr = 1'b1;
            S_MEM_RD:    bus.mem_cmd   = 2'b01;
            // Read command stays up so mdata is still valid during writeback.
            S_WRITE_MEM: begin
                bus.mem_cmd = 2'b01;
                bus.nsel    = 3'b010;
                bus.vsel    = 2'b01;
                bus.write   = 1'b1;
            end
            S_GET_RD: begin
                bus.nsel  = 3'b010;
                bus.loadb = 1'b1;
            end
            // Pass Rd through the ALU (A forced to 0) so C carries the store data.
            S_PASS: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_MEM_WR: bus.mem_cmd = 2'b10;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// tb/tb_cpu_controller_fsm.sv - self-checking bench for cpu_controller_fsm
module tb_cpu_controller_fsm;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    cpu_controller_fsm_if bus ();

    cpu_controller_fsm #(.STATE_BITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output word: {w, nsel[3], vsel[2], write, loada, loadb, asel, bsel, loadc, loads, mem_cmd[2], load_addr}
    localparam logic [15:0] V_W        = 16'h8000;
    localparam logic [15:0] NSEL_RN    = 16'h1000;
    localparam logic [15:0] NSEL_RD    = 16'h2000;
    localparam logic [15:0] NSEL_RM    = 16'h4000;
    localparam logic [15:0] VSEL_MDATA = 16'h0400;
    localparam logic [15:0] VSEL_IMM   = 16'h0800;
    localparam logic [15:0] F_WRITE    = 16'h0200;
    localparam logic [15:0] F_LOADA    = 16'h0100;
    localparam logic [15:0] F_LOADB    = 16'h0080;
    localparam logic [15:0] F_ASEL     = 16'h0040;
    localparam logic [15:0] F_BSEL     = 16'h0020;
    localparam logic [15:0] F_LOADC    = 16'h0010;
    localparam logic [15:0] F_LOADS    = 16'h0008;
    localparam logic [15:0] M_READ     = 16'h0002;
    localparam logic [15:0] M_WRITE    = 16'h0004;
    localparam logic [15:0] F_LDADDR   = 16'h0001;

    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];

    function automatic logic [15:0] outv();
        return {bus.w, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.asel,
                bus.bsel, bus.loadc, bus.loads, bus.mem_cmd, bus.load_addr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the micro-step list each instruction must produce, one word per
    // clock edge after s is sampled, ending with the idle word.
    task automatic build_model(input logic [2:0] opc, input logic [1:0] o);
        logic [15:0] ga, gb, wr;
        ga = NSEL_RN | F_LOADA;
        gb = NSEL_RM | F_LOADB;
        wr = NSEL_RD | F_WRITE;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        case ({opc, o})
            5'b11010: exp_q.push_back(NSEL_RN | VSEL_IMM | F_WRITE);
            5'b11000: begin exp_q.push_back(gb); exp_q.push_back(F_LOADC | F_ASEL); exp_q.push_back(wr); end
            5'b10100, 5'b10110: begin
                exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(F_LOADC); exp_q.push_back(wr);
            end
            5'b10101: begin exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(F_LOADS); end
            5'b10111: begin exp_q.push_back(gb); exp_q.push_back(F_LOADC | F_ASEL); exp_q.push_back(wr); end
`ifdef CPU_LDR_STR_EN
            5'b01100: begin
                exp_q.push_back(ga); exp_q.push_back(F_BSEL | F_LOADC); exp_q.push_back(F_LDADDR);
                exp_q.push_back(M_READ); exp_q.push_back(M_READ | NSEL_RD | VSEL_MDATA | F_WRITE);
            end
            5'b10000: begin
                exp_q.push_back(ga); exp_q.push_back(F_BSEL | F_LOADC); exp_q.push_back(F_LDADDR);
                exp_q.push_back(NSEL_RD | F_LOADB); exp_q.push_back(F_ASEL | F_LOADC); exp_q.push_back(M_WRITE);
            end
`endif
            default: ;
        endcase
        exp_q.push_back(V_W);
    endtask

    // Starts one instruction and records outputs after each edge until idle (bounded).
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit noise);
        act_q.delete();
        @(negedge clk);
        bus.opcode = opc;
        bus.op     = o;
        bus.s      = 1'b1;
        @(posedge clk); #1;
        bus.s = 1'b0;
        act_q.push_back(outv());
        while (!act_q[act_q.size()-1][15] && act_q.size() < 40) begin
            if (noise) bus.s = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            act_q.push_back(outv());
        end
        bus.s = 1'b0;
    endtask

    task automatic compare_trace(input string name);
        int n;
        check({name, "_len"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_step%0d", name, i), act_q[i], exp_q[i]);
            check($sformatf("%s_excl%0d", name, i),
                  $countones({act_q[i][9], act_q[i][8], act_q[i][7], act_q[i][4], act_q[i][3]}) <= 1, 1);
        end
    endtask

    typedef struct {
        string      name;
        logic [2:0] opc;
        logic [1:0] op;
        int         lat;
        int         writes;
        int         loads_n;
        int         mem_n;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int wr_n, ls_n, mm_n;
        logic [2:0] ropc;
        logic [1:0] rop;

        tbl[0] = '{"movi", 3'b110, 2'b10, 3, 1, 0, 0};
        tbl[1] = '{"movr", 3'b110, 2'b00, 5, 1, 0, 0};
        tbl[2] = '{"add",  3'b101, 2'b00, 6, 1, 0, 0};
        tbl[3] = '{"cmp",  3'b101, 2'b01, 5, 0, 1, 0};
        tbl[4] = '{"and",  3'b101, 2'b10, 6, 1, 0, 0};
        tbl[5] = '{"mvn",  3'b101, 2'b11, 5, 1, 0, 0};
        tbl[6] = '{"nop0", 3'b000, 2'b00, 2, 0, 0, 0};
        tbl[7] = '{"nop1", 3'b110, 2'b01, 2, 0, 0, 0};
`ifdef CPU_LDR_STR_EN
        tbl[8] = '{"ldr",  3'b011, 2'b00, 7, 1, 0, 2};
        tbl[9] = '{"str",  3'b100, 2'b00, 8, 0, 0, 1};
`else
        tbl[8] = '{"ldr",  3'b011, 2'b00, 2, 0, 0, 0};
        tbl[9] = '{"str",  3'b100, 2'b00, 2, 0, 0, 0};
`endif

        reset = 1'b1; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
        #1;
        check("reset_outputs", outv(), V_W);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", outv(), V_W);

        // Directed table
        foreach (tbl[k]) begin
            run_instr(tbl[k].opc, tbl[k].op, 1'b0);
            build_model(tbl[k].opc, tbl[k].op);
            compare_trace(tbl[k].name);
            wr_n = 0; ls_n = 0; mm_n = 0;
            foreach (act_q[i]) begin
                wr_n += int'(act_q[i][9]);
                ls_n += int'(act_q[i][3]);
                mm_n += (act_q[i][2:1] != 2'b00) ? 1 : 0;
            end
            check({tbl[k].name, "_latency"}, act_q.size(), tbl[k].lat);
            check({tbl[k].name, "_writes"},  wr_n, tbl[k].writes);
            check({tbl[k].name, "_loads"},   ls_n, tbl[k].loads_n);
            check({tbl[k].name, "_memcyc"},  mm_n, tbl[k].mem_n);
        end

        // Async reset in the middle of ADD (GET_B), no clock edge needed
        @(negedge clk);
        bus.opcode = 3'b101; bus.op = 2'b00; bus.s = 1'b1;
        @(posedge clk); #1; bus.s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midadd_getb", outv(), NSEL_RM | F_LOADB);
        #2; reset = 1'b1;
        #1;
        check("midadd_async_reset", outv(), V_W);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("midadd_after_release", outv(), V_W);

        // Held s: back-to-back MOV imm with a single idle cycle between
        @(negedge clk);
        bus.opcode = 3'b110; bus.op = 2'b10; bus.s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("held_s_w%0d", i), bus.w, (i % 3 == 2) ? 1 : 0);
        end
        bus.s = 1'b0;
        @(posedge clk); #1;
        check("held_s_release_idle", outv(), V_W);

        // HALT is sticky regardless of s, only reset leaves it
        @(negedge clk);
        bus.opcode = 3'b111; bus.op = 2'($urandom_range(0, 3)); bus.s = 1'b1;
        @(posedge clk); #1; bus.s = 1'b0;
        @(posedge clk); #1;
        check("halt_enter", outv(), 16'h0000);
        for (int i = 0; i < 20; i++) begin
            bus.s = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check($sformatf("halt_hold%0d", i), outv(), 16'h0000);
        end
        @(negedge clk); reset = 1'b1; bus.s = 1'b0;
        #1;
        check("halt_reset", outv(), V_W);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("halt_exit_idle", outv(), V_W);

        // Random instructions with s noise while busy
        for (int r = 0; r < 40; r++) begin
            ropc = 3'($urandom_range(0, 7));
            rop  = 2'($urandom_range(0, 3));
            if (ropc == 3'b111) ropc = 3'b101;
            run_instr(ropc, rop, 1'b1);
            build_model(ropc, rop);
            compare_trace($sformatf("rnd%0d_%03b_%02b", r, ropc, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
